// File: rtl/stripe_scroll_sequencer_pkg.sv
// Shared constants and state encoding for the stripe scroll sequencer.
// Imported by the interface, the frame detector user and the top.
package stripe_seq_pkg;

    localparam int OFFSET_W = 10;
    localparam int SPEED_W  = 3;
    localparam int VPOS_W   = 10;

    localparam int DEF_LIMIT      = 320;
    localparam int DEF_DWELL      = 30;
    localparam int DEF_PAL_PERIOD = 64;

    // Low-end dwell has no code of its own; it is REV plus an internal flag.
    typedef enum logic [1:0] {
        MAN      = 2'd0,
        FWD      = 2'd1,
        DWELL_HI = 2'd2,
        REV      = 2'd3
    } seq_state_t;

endpackage

// File: rtl/stripe_scroll_sequencer_if.sv
// Config-in / scroll-out bundle between the pins and the sequencer.
// master drives vpos and config, slave is the sequencer.
interface stripe_scroll_sequencer_if;
    import stripe_seq_pkg::*;

    logic [VPOS_W-1:0]   vpos;
    logic [SPEED_W-1:0]  speed;
    logic                dir;
    logic                pause;
    logic                auto_mode;
    logic [OFFSET_W-1:0] offset_x;
    logic [1:0]          palette_sel;
    logic                frame_tick;
    logic [1:0]          state;

    modport master (
        output vpos, speed, dir, pause, auto_mode,
        input  offset_x, palette_sel, frame_tick, state
    );

    modport slave (
        input  vpos, speed, dir, pause, auto_mode,
        output offset_x, palette_sel, frame_tick, state
    );

endinterface

// File: rtl/stripe_scroll_sequencer_frame_start_detect.sv
// Frame start detector: flags the first cycle vpos returns to 0.
// Reusable by any block that updates once per frame.
module frame_start_detect #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] vpos,
    output logic         start_evt,
    output logic         frame_tick
);

    logic [W-1:0] prev_vpos_q, prev_vpos_d;
    logic         frame_tick_q, frame_tick_d;

    // Edge into line 0, and the next-cycle tick it produces
    always_comb begin
        start_evt    = (vpos == '0) && (prev_vpos_q != '0);
        prev_vpos_d  = vpos;
        frame_tick_d = start_evt;
    end

    // History of vpos and the registered tick
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_vpos_q  <= '0;
            frame_tick_q <= 1'b0;
        end else begin
            prev_vpos_q  <= prev_vpos_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign frame_tick = frame_tick_q;

endmodule

// File: rtl/stripe_scroll_sequencer.sv
// Per-frame scroll offset / palette sequencer for the stripe pattern.
// All state moves only on a frame start, so outputs never tear mid-frame.
module stripe_scroll_sequencer
    import stripe_seq_pkg::*;
#(
    parameter int LIMIT      = DEF_LIMIT,
    parameter int DWELL      = DEF_DWELL,
    parameter int PAL_PERIOD = DEF_PAL_PERIOD
) (
    input  logic                        clk,
    input  logic                        reset,
    stripe_scroll_sequencer_if.slave    bus
);

    localparam int DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int PC_W = (PAL_PERIOD > 1) ? $clog2(PAL_PERIOD) : 1;

    localparam logic [OFFSET_W:0]   LIMIT_X    = (OFFSET_W+1)'(LIMIT);
    localparam logic [OFFSET_W-1:0] LIMIT_O    = OFFSET_W'(LIMIT);
    localparam logic [DW_W-1:0]     DWELL_LAST = DW_W'(DWELL - 1);
    localparam logic [PC_W-1:0]     PAL_LAST   = PC_W'(PAL_PERIOD - 1);

    logic start_evt;
    logic frame_tick;

    frame_start_detect #(
        .W (VPOS_W)
    ) u_fsd (
        .clk        (clk),
        .reset      (reset),
        .vpos       (bus.vpos),
        .start_evt  (start_evt),
        .frame_tick (frame_tick)
    );

    seq_state_t          state_q, state_d;
    logic                lo_hold_q, lo_hold_d;
    logic [OFFSET_W-1:0] offset_q, offset_d;
    logic [DW_W-1:0]     dwell_q, dwell_d;
    logic [PC_W-1:0]     pal_cnt_q, pal_cnt_d;
    logic [1:0]          pal_q, pal_d;

    seq_state_t          eff_state;
    logic                eff_lo;
    logic [OFFSET_W-1:0] spd;
    logic [OFFSET_W:0]   sum;

    // Next frame's offset, mode and palette, evaluated only on a frame start
    always_comb begin
        state_d   = state_q;
        lo_hold_d = lo_hold_q;
        offset_d  = offset_q;
        dwell_d   = dwell_q;
        pal_cnt_d = pal_cnt_q;
        pal_d     = pal_q;
        eff_state = MAN;
        eff_lo    = 1'b0;
        spd       = OFFSET_W'(bus.speed);
        sum       = {1'b0, offset_q} + {1'b0, spd};

        if (start_evt && !bus.pause) begin
            if (pal_cnt_q == PAL_LAST) begin
                pal_cnt_d = '0;
                pal_d     = pal_q + 2'd1;
            end else begin
                pal_cnt_d = pal_cnt_q + PC_W'(1);
            end

            // A mode switch takes effect on this tick and runs the new rule
            if (!bus.auto_mode) begin
                eff_state = MAN;
            end else if (state_q == MAN) begin
                eff_state = FWD;
            end else begin
                eff_state = state_q;
            end
            eff_lo    = bus.auto_mode && lo_hold_q;
            state_d   = eff_state;
            lo_hold_d = eff_lo;

            unique case (eff_state)
                MAN: begin
                    offset_d = bus.dir ? offset_q - spd : offset_q + spd;
                end
                FWD: begin
                    if (sum >= LIMIT_X) begin
                        offset_d = LIMIT_O;
                        state_d  = DWELL_HI;
                        dwell_d  = DWELL_LAST;
                    end else begin
                        offset_d = sum[OFFSET_W-1:0];
                    end
                end
                DWELL_HI: begin
                    if (dwell_q == '0) begin
                        state_d = REV;
                    end else begin
                        dwell_d = dwell_q - DW_W'(1);
                    end
                end
                REV: begin
                    if (eff_lo) begin
                        if (dwell_q == '0) begin
                            lo_hold_d = 1'b0;
                            state_d   = FWD;
                        end else begin
                            dwell_d = dwell_q - DW_W'(1);
                        end
                    end else if (offset_q <= spd) begin
                        offset_d  = '0;
                        lo_hold_d = 1'b1;
                        dwell_d   = DWELL_LAST;
                    end else begin
                        offset_d = offset_q - spd;
                    end
                end
            endcase
        end
    end

    // Sequencer state, held between frame starts
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= MAN;
            lo_hold_q <= 1'b0;
            offset_q  <= '0;
            dwell_q   <= '0;
            pal_cnt_q <= '0;
            pal_q     <= '0;
        end else begin
            state_q   <= state_d;
            lo_hold_q <= lo_hold_d;
            offset_q  <= offset_d;
            dwell_q   <= dwell_d;
            pal_cnt_q <= pal_cnt_d;
            pal_q     <= pal_d;
        end
    end

    assign bus.offset_x    = offset_q;
    assign bus.palette_sel = pal_q;
    assign bus.frame_tick  = frame_tick;
    assign bus.state       = state_q;

endmodule

// File: tb/tb_stripe_scroll_sequencer.sv
// Directed bench for stripe_scroll_sequencer with hand-computed expectations.
// Frames are short: vpos goes 1 then 0, so each frame is three clocks.
module tb_stripe_scroll_sequencer;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_bad;
    int   tick_cnt;
    int   t0;

    stripe_scroll_sequencer_if bus ();

    stripe_scroll_sequencer u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count frame_tick pulses
    always @(posedge clk) begin
        if (reset) tick_cnt = 0;
        else if (bus.frame_tick) tick_cnt = tick_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (got !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One short frame; returns on the negedge where the tick is visible
    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk) bus.vpos = 10'd1;
            @(negedge clk) bus.vpos = 10'd0;
            @(negedge clk);
        end
    endtask

    task automatic chk_os(input string tag, input int off, input int st);
        chk({tag, "_off"}, 32'(bus.offset_x), off);
        chk({tag, "_st"}, 32'(bus.state), st);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        n_cmp = 0;
        n_bad = 0;
        tick_cnt = 0;
        reset = 1'b1;
        bus.vpos = '0;
        bus.speed = '0;
        bus.dir = 1'b0;
        bus.pause = 1'b0;
        bus.auto_mode = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_off", 32'(bus.offset_x), 0);
        chk("rst_pal", 32'(bus.palette_sel), 0);
        chk("rst_st", 32'(bus.state), 0);
        chk("rst_tick", 32'(bus.frame_tick), 0);
        reset = 1'b0;

        // vpos held at 0 from reset: no tick
        repeat (3) @(negedge clk);
        chk("idle_ticks", tick_cnt, 0);
        bus.vpos = 10'd524;
        @(negedge clk) bus.vpos = 10'd0;
        @(negedge clk);
        chk("sweep_tick_hi", 32'(bus.frame_tick), 1);
        @(negedge clk);
        chk("sweep_tick_lo", 32'(bus.frame_tick), 0);
        repeat (4) @(negedge clk);
        chk("sweep_ticks", tick_cnt, 1);
        chk_os("sweep", 0, 0);

        // Manual scroll and wrap (10 unpaused ticks by the end)
        bus.speed = 3'd3;
        frames(4);
        chk_os("man_fwd", 12, 0);
        bus.dir = 1'b1;
        bus.speed = 3'd5;
        frames(2);
        chk_os("man_rev", 2, 0);
        frames(1);
        chk_os("man_wrap_lo", 1021, 0);
        bus.dir = 1'b0;
        frames(1);
        chk_os("man_wrap_hi", 2, 0);
        bus.dir = 1'b1;
        bus.speed = 3'd2;
        frames(1);
        chk_os("man_zero", 0, 0);

        // Auto ping-pong, speed 7 from 0 (153 ticks)
        bus.auto_mode = 1'b1;
        bus.speed = 3'd7;
        frames(1);
        chk_os("auto_t1", 7, 1);
        frames(44);
        chk_os("auto_t45", 315, 1);
        frames(1);
        chk_os("auto_t46", 320, 2);
        frames(29);
        chk_os("auto_t75", 320, 2);
        frames(1);
        chk_os("auto_t76", 320, 3);
        frames(1);
        chk_os("auto_t77", 313, 3);
        frames(44);
        chk_os("auto_t121", 5, 3);
        frames(1);
        chk_os("auto_t122", 0, 3);
        frames(29);
        chk_os("auto_t151", 0, 3);
        frames(1);
        chk_os("auto_t152", 0, 1);
        frames(1);
        chk_os("auto_t153", 7, 1);

        // Back to manual on the same tick, then walk to 100 (179 ticks)
        bus.auto_mode = 1'b0;
        bus.dir = 1'b0;
        bus.speed = 3'd3;
        frames(1);
        chk_os("to_man", 10, 0);
        bus.speed = 3'd6;
        frames(15);
        chk_os("at_100", 100, 0);
        chk("pal_179", 32'(bus.palette_sel), 2);

        // Pause: ticks continue, nothing else moves
        @(negedge clk);
        t0 = tick_cnt;
        bus.pause = 1'b1;
        bus.speed = 3'd5;
        frames(10);
        @(negedge clk);
        chk("pause_ticks", tick_cnt - t0, 10);
        chk_os("pause", 100, 0);
        chk("pause_pal", 32'(bus.palette_sel), 2);

        // Speed change mid-frame has no effect until the frame start
        bus.pause = 1'b0;
        bus.speed = 3'd0;
        @(negedge clk) bus.vpos = 10'd200;
        @(negedge clk) bus.speed = 3'd7;
        repeat (3) @(negedge clk);
        chk("midframe_off", 32'(bus.offset_x), 100);
        bus.vpos = 10'd0;
        @(negedge clk);
        chk("midframe_tick_off", 32'(bus.offset_x), 107);
        bus.speed = 3'd0;
        frames(11);
        chk("pal_191", 32'(bus.palette_sel), 2);
        frames(1);
        chk("pal_192", 32'(bus.palette_sel), 3);

        // Auto from 107, into DWELL_HI, then reset mid-frame
        bus.auto_mode = 1'b1;
        bus.speed = 3'd7;
        frames(30);
        chk_os("auto2_317", 317, 1);
        frames(1);
        chk_os("auto2_320", 320, 2);
        frames(3);
        @(negedge clk) bus.vpos = 10'd100;
        @(negedge clk) reset = 1'b1;
        @(negedge clk);
        chk_os("midrst", 0, 0);
        chk("midrst_pal", 32'(bus.palette_sel), 0);
        chk("midrst_tick", 32'(bus.frame_tick), 0);
        bus.vpos = 10'd0;
        bus.auto_mode = 1'b0;
        bus.speed = 3'd0;
        bus.dir = 1'b0;
        @(negedge clk) reset = 1'b0;
        repeat (4) @(negedge clk);
        chk("postrst_ticks", tick_cnt, 0);

        // Clamp on auto entry above LIMIT, with speed 0
        bus.dir = 1'b1;
        bus.speed = 3'd6;
        frames(1);
        chk_os("pre_clamp", 1018, 0);
        bus.auto_mode = 1'b1;
        bus.speed = 3'd0;
        frames(1);
        chk_os("entry_clamp", 320, 2);
        bus.auto_mode = 1'b0;
        frames(1);
        chk_os("leave_auto", 320, 0);

        // Palette rollover counted from reset (3 ticks so far)
        frames(60);
        chk("pal_63", 32'(bus.palette_sel), 0);
        frames(1);
        chk("pal_64", 32'(bus.palette_sel), 1);
        frames(191);
        chk("pal_255", 32'(bus.palette_sel), 3);
        frames(1);
        chk("pal_256", 32'(bus.palette_sel), 0);
        chk_os("final", 320, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
